interp4x_sched: RTL and testbench

- Rate scheduler and sample feeder for the 4X linear interpolator in the FM modulator datapath.
- Generates the paired clock enables clkenin (Fs) and clken4x (4·Fs) from the master clock, with a runtime-programmable divider.
- Buffers upstream samples in a small FIFO with a valid/ready handshake and presents one sample per Fs frame on xkin.
- Detects and flags underruns when no sample is available at a frame boundary.

---
 rtl/interp4x_sched_pkg.sv | 7 +
 rtl/interp4x_sched_fifo.sv | 52 +++++
 rtl/interp4x_sched.sv | 139 +++++++++++++
 tb/tb_interp4x_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/interp4x_sched_pkg.sv
// Shared widths and FSM state encoding for the 4X interpolator scheduler.
package interp4x_pkg;
    localparam int unsigned SAMPLE_W = 18;
    localparam int unsigned UPSAMPLE = 4;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
endpackage

// File: rtl/interp4x_sched_fifo.sv
// Synchronous sample FIFO (module sync_fifo_s18); DEPTH must be a power of 2.
module sync_fifo_s18
    import interp4x_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_push,
    input  logic [SAMPLE_W-1:0] i_data,
    input  logic                i_pop,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_full,
    output logic                o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/interp4x_sched.sv
// Fs / 4*Fs enable generator and sample feeder for the 4X interpolator.
// Optional underrun event counter: define INTERP4X_SCHED_UNDERRUN_CNT_EN.
module interp4x_sched
    import interp4x_pkg::*;
#(
    parameter int unsigned DIVW          = 12,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned UNDERRUN_HOLD = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [DIVW-1:0] div_cfg,
    input  logic [17:0]     s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            clkenin,
    output logic            clken4x,
    output logic [17:0]     xkin,
    output logic [1:0]      phase,
    output logic            running,
    output logic            underrun,
    input  logic            clr_underrun
`ifdef INTERP4X_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [15:0]     underrun_cnt
`endif
);
    localparam int unsigned PHASE_W = $clog2(UPSAMPLE);

    state_t              r_state;
    state_t              w_state_d;
    logic [DIVW-1:0]     r_cnt;
    logic [DIVW-1:0]     r_div_lat;
    logic [DIVW-1:0]     w_lim;
    logic [PHASE_W-1:0]  r_phase;
    logic                r_clken4x;
    logic                r_underrun;
    logic [SAMPLE_W-1:0] r_xkin;
    logic [SAMPLE_W-1:0] w_fifo_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_start;
    logic                w_tick;
    logic                w_clkenin;
    logic                w_urun_evt;

    sync_fifo_s18 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_push     = s_valid & ~w_fifo_full;
    assign w_clkenin  = r_clken4x & (r_phase == '0);
    assign w_start    = (r_state == PRIME) & enable & ~w_fifo_empty;
    assign w_pop      = (w_start | w_clkenin) & ~w_fifo_empty;
    assign w_urun_evt = w_clkenin & w_fifo_empty;
    // A new div_cfg is compared from the frame-start cycle so the very next period uses it.
    assign w_lim      = w_clkenin ? div_cfg : r_div_lat;
    assign w_tick     = (r_state == RUN) & enable & (r_cnt == w_lim);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (enable) w_state_d = PRIME;
            PRIME: begin
                if (!enable)            w_state_d = IDLE;
                else if (!w_fifo_empty) w_state_d = RUN;
            end
            RUN:     if (!enable) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div_lat  <= '0;
            r_phase    <= '0;
            r_clken4x  <= 1'b0;
            r_xkin     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_clken4x <= w_tick;
            if (r_state != RUN || w_state_d != RUN) begin
                r_cnt   <= '0;
                r_phase <= '0;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + DIVW'(1);
                if (r_clken4x) r_phase <= r_phase + PHASE_W'(1);
            end
            if (w_start || w_clkenin) r_div_lat <= div_cfg;
            if (w_pop) begin
                r_xkin <= w_fifo_data;
            end else if (w_urun_evt && UNDERRUN_HOLD == 0) begin
                r_xkin <= '0;
            end
            if (w_urun_evt)        r_underrun <= 1'b1;
            else if (clr_underrun) r_underrun <= 1'b0;
        end
    end

`ifdef INTERP4X_SCHED_UNDERRUN_CNT_EN
    logic [15:0] r_urun_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_urun_cnt <= '0;
        end else if (w_urun_evt) begin
            if (clr_underrun)                r_urun_cnt <= 16'd1;
            else if (r_urun_cnt != 16'hFFFF) r_urun_cnt <= r_urun_cnt + 16'd1;
        end else if (clr_underrun) begin
            r_urun_cnt <= '0;
        end
    end

    assign underrun_cnt = r_urun_cnt;
`endif

    assign s_ready  = ~w_fifo_full;
    assign clkenin  = w_clkenin;
    assign clken4x  = r_clken4x;
    assign xkin     = r_xkin;
    assign phase    = r_phase;
    assign running  = (r_state == RUN);
    assign underrun = r_underrun;
endmodule

// File: tb/tb_interp4x_sched.sv
// Directed bench for interp4x_sched: vector table plus multi-cycle sequences.
module tb_interp4x_sched;
    logic        clock;
    logic        reset;
    logic        enable;
    logic [11:0] div_cfg;
    logic [17:0] s_data;
    logic        s_valid;
    logic        clr_underrun;
    logic        s_ready, clkenin, clken4x, running, underrun;
    logic [17:0] xkin;
    logic [1:0]  phase;
    logic        h_s_ready, h_clkenin, h_clken4x, h_running, h_underrun;
    logic [17:0] h_xkin;
    logic [1:0]  h_phase;
`ifdef INTERP4X_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt, h_underrun_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    interp4x_sched #(.DIVW(12), .FIFO_DEPTH(4), .UNDERRUN_HOLD(0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .div_cfg(div_cfg),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .clkenin(clkenin),
        .clken4x(clken4x), .xkin(xkin), .phase(phase), .running(running),
        .underrun(underrun), .clr_underrun(clr_underrun)
`ifdef INTERP4X_SCHED_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    interp4x_sched #(.DIVW(12), .FIFO_DEPTH(4), .UNDERRUN_HOLD(1)) dut_h (
        .clock(clock), .reset(reset), .enable(enable), .div_cfg(div_cfg),
        .s_data(s_data), .s_valid(s_valid), .s_ready(h_s_ready), .clkenin(h_clkenin),
        .clken4x(h_clken4x), .xkin(h_xkin), .phase(h_phase), .running(h_running),
        .underrun(h_underrun), .clr_underrun(clr_underrun)
`ifdef INTERP4X_SCHED_UNDERRUN_CNT_EN
        , .underrun_cnt(h_underrun_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int rst, en, vld, clr, data, div;
        int ce, ce4, ph, run, ur, rdy, x, xh;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rst, en, vld, clr, data, div,
                       input int ce, ce4, ph, run, ur, rdy, x, xh);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.clr = clr; v.data = data; v.div = div;
        v.ce = ce; v.ce4 = ce4; v.ph = ph; v.run = run; v.ur = ur; v.rdy = rdy;
        v.x = x; v.xh = xh;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; clr_underrun = 1'b0;
        s_data = '0; div_cfg = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_n(input int n, input int first);
        s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_data = 18'(first + i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] act, exp;
        int t_run, n_in, found, gap, k;
        logic acc;
        int exp_gap[4] = '{4, 4, 2, 2};

        // Table: three samples at div 0, then underruns, clear, set-wins, enable drop.
        //   rst en vld clr data div | ce ce4 ph run ur rdy  x    xh
        add(1, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0, 1,    0,    0);
        add(0, 0, 1, 0,  100, 0,  0, 0, 0, 0, 0, 1,    0,    0);
        add(0, 0, 1, 0, -200, 0,  0, 0, 0, 0, 0, 1,    0,    0);
        add(0, 0, 1, 0,  300, 0,  0, 0, 0, 0, 0, 1,    0,    0);
        add(0, 1, 0, 0,    0, 0,  0, 0, 0, 0, 0, 1,    0,    0);
        add(0, 1, 0, 0,    0, 0,  0, 0, 0, 1, 0, 1,  100,  100);
        add(0, 1, 0, 0,    0, 0,  1, 1, 0, 1, 0, 1,  100,  100);
        add(0, 1, 0, 0,    0, 0,  0, 1, 1, 1, 0, 1, -200, -200);
        add(0, 1, 0, 0,    0, 0,  0, 1, 2, 1, 0, 1, -200, -200);
        add(0, 1, 0, 0,    0, 0,  0, 1, 3, 1, 0, 1, -200, -200);
        add(0, 1, 0, 0,    0, 0,  1, 1, 0, 1, 0, 1, -200, -200);
        add(0, 1, 0, 0,    0, 0,  0, 1, 1, 1, 0, 1,  300,  300);
        add(0, 1, 0, 0,    0, 0,  0, 1, 2, 1, 0, 1,  300,  300);
        add(0, 1, 0, 0,    0, 0,  0, 1, 3, 1, 0, 1,  300,  300);
        add(0, 1, 0, 0,    0, 0,  1, 1, 0, 1, 0, 1,  300,  300);
        add(0, 1, 0, 0,    0, 0,  0, 1, 1, 1, 1, 1,    0,  300);
        add(0, 1, 0, 1,    0, 0,  0, 1, 2, 1, 0, 1,    0,  300);
        add(0, 1, 0, 0,    0, 0,  0, 1, 3, 1, 0, 1,    0,  300);
        add(0, 1, 0, 0,    0, 0,  1, 1, 0, 1, 0, 1,    0,  300);
        add(0, 1, 0, 0,    0, 0,  0, 1, 1, 1, 1, 1,    0,  300);
        add(0, 1, 0, 1,    0, 0,  0, 1, 2, 1, 0, 1,    0,  300);
        add(0, 1, 0, 0,    0, 0,  0, 1, 3, 1, 0, 1,    0,  300);
        add(0, 1, 0, 0,    0, 0,  1, 1, 0, 1, 0, 1,    0,  300);
        add(0, 1, 0, 1,    0, 0,  0, 1, 1, 1, 1, 1,    0,  300);
        add(0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 1, 1,    0,  300);

        do_reset();
        foreach (vecs[i]) begin
            reset = 1'(vecs[i].rst); enable = 1'(vecs[i].en); s_valid = 1'(vecs[i].vld);
            clr_underrun = 1'(vecs[i].clr); s_data = 18'(vecs[i].data);
            div_cfg = 12'(vecs[i].div);
            tick();
            act = 64'({clkenin, clken4x, phase, running, underrun, s_ready, xkin, h_xkin});
            exp = 64'({1'(vecs[i].ce), 1'(vecs[i].ce4), 2'(vecs[i].ph), 1'(vecs[i].run),
                       1'(vecs[i].ur), 1'(vecs[i].rdy), 18'(vecs[i].x), 18'(vecs[i].xh)});
            check($sformatf("vec%0d", i), act, exp);
        end
`ifdef INTERP4X_SCHED_UNDERRUN_CNT_EN
        check("urun_cnt_table", 64'(underrun_cnt), 64'd1);
`endif

        // div 3 with continuous upstream: 4-cycle pulses, 16-cycle frames, in-order samples.
        do_reset();
        enable = 1'b1; div_cfg = 12'd3; s_valid = 1'b1; s_data = 18'd1;
        t_run = -1; n_in = 0;
        for (int c = 0; c < 80; c++) begin
            acc = s_valid & s_ready;
            tick();
            if (acc) s_data = s_data + 18'd1;
            if (running && t_run < 0) t_run = c;
            if (t_run >= 0) begin
                int d, np, e4;
                d  = c - t_run;
                np = (d > 0) ? (d - 1) / 4 : 0;
                e4 = (d > 0 && d % 4 == 0) ? 1 : 0;
                check($sformatf("div3_c%0d", c), 64'({clken4x, clkenin, phase}),
                      64'({1'(e4), 1'(e4 == 1 && np % 4 == 0), 2'(np % 4)}));
                if (clkenin) begin
                    check($sformatf("div3_xkin%0d", n_in), 64'(xkin), 64'(n_in + 1));
                    n_in++;
                end
            end
        end
        check("div3_run_start", 64'(t_run), 64'd1);
        check("div3_frames", 64'(n_in), 64'd5);

        // FIFO fill with enable low, then acceptance resumes after the first pop.
        do_reset();
        s_valid = 1'b1; s_data = 18'd10;
        for (int i = 0; i < 5; i++) begin
            acc = s_valid & s_ready;
            tick();
            if (acc) s_data = s_data + 18'd1;
            check($sformatf("fill_rdy%0d", i), 64'(s_ready), 64'(i < 3));
        end
        enable = 1'b1; div_cfg = 12'd0;
        tick();
        check("fill_prime", 64'({running, s_ready}), 64'(2'b00));
        tick();
        check("fill_first_pop", 64'({running, s_ready, xkin}), 64'({2'b11, 18'd10}));
        tick();
        check("fill_refull", 64'({s_ready, clken4x}), 64'(2'b01));

        // div_cfg 3 -> 1 during phase 2: gaps 4,4 then 2,2 after the next frame start.
        do_reset();
        push_n(4, 1);
        enable = 1'b1; div_cfg = 12'd3;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            tick();
            if (clken4x && phase == 2'd2) found = 1;
        end
        check("divchg_ph2_seen", 64'(found), 64'd1);
        div_cfg = 12'd1;
        gap = 0; k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            tick();
            gap++;
            if (clken4x) begin
                check($sformatf("divchg_gap%0d", k), 64'(gap), 64'(exp_gap[k]));
                gap = 0;
                k++;
            end
        end
        check("divchg_pulses", 64'(k), 64'd4);

        // Reset in RUN with three samples queued and a pulse about to issue.
        do_reset();
        push_n(4, 7);
        enable = 1'b1; div_cfg = 12'd3;
        tick();
        tick();
        check("rst_pre_run", 64'({running, xkin}), 64'({1'b1, 18'd7}));
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_state", 64'({clkenin, clken4x, phase, running, underrun, s_ready, xkin}),
              64'({6'b000001, 18'd0}));
`ifdef INTERP4X_SCHED_UNDERRUN_CNT_EN
        check("rst_urun_cnt", 64'(underrun_cnt), 64'd0);
`endif
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("rst_fifo_empty", 64'({running, clken4x}), 64'(2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
